// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encoding and flag bit positions.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT1 = 4'h6;
    localparam logic [3:0] OP_NOT2 = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_DEC  = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // flags = {dz, carry, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_DZ    = 2;

    function automatic logic is_iterative(input logic [3:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle
// over WIDTH cycles, sharing a {hi, lo} accumulator.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             dz_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             running_q, running_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last_step;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted[WIDTH-1:0] - b_q;
        step_hi = '0;
        step_lo = '0;
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                step_hi = trial;
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_step = running_q && (count_q == LAST);

    always_comb begin
        running_d = running_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        div_d     = div_q;
        dz_d      = dz_q;
        if (start_i) begin
            running_d = 1'b1;
            count_d   = '0;
            hi_d      = '0;
            lo_d      = div_i ? a_i : b_i;
            b_d       = div_i ? b_i : a_i;
            div_d     = div_i;
            dz_d      = div_i && (b_i == '0);
        end else if (running_q) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            count_d = count_q + 1'b1;
            if (last_step) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            div_q     <= div_d;
            dz_q      <= dz_d;
        end
    end

    // Result is presented combinationally from the final step so the top can
    // capture it on the same edge that completes the last iteration.
    assign done_o   = last_step;
    assign result_o = step_lo;
    assign carry_o  = !div_q && (step_hi != '0);
    assign dz_o     = dz_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops finish in one cycle, mul/div run in the
// iterative unit; results are held until the consumer takes them.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; a result stays frozen while out_valid is high and out_ready is low.

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       flags_q, flags_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   wide;
    logic             shift_oob;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             md_carry;
    logic             md_dz;

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign md_start = accept && is_iterative(code);
    assign shift_oob = (op2 >= SHIFT_LIMIT);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        wide      = '0;
        case (code)
            OP_ADD: begin
                wide      = {1'b0, op1} + {1'b0, op2};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SUB: begin
                alu_res   = op1 - op2;
                alu_carry = (op1 < op2);
            end
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_NOT1: alu_res = ~op1;
            OP_NOT2: alu_res = ~op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_XNOR: alu_res = ~(op1 ^ op2);
            OP_NAND: alu_res = ~(op1 & op2);
            OP_NOR:  alu_res = ~(op1 | op2);
            OP_SHL:  alu_res = shift_oob ? '0 : (op1 << op2);
            OP_SHR:  alu_res = shift_oob ? '0 : (op1 >> op2);
            OP_INC: begin
                wide      = {1'b0, op1} + (WIDTH+1)'(1);
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_DEC: begin
                alu_res   = op1 - WIDTH'(1);
                alu_carry = (op1 == '0);
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .div_i   (code == OP_DIV),
        .a_i     (op1),
        .b_i     (op2),
        .done_o  (md_done),
        .result_o(md_result),
        .carry_o (md_carry),
        .dz_o    (md_dz)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iterative(code)) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d                 = ST_DONE;
                        out_d                   = alu_res;
                        flags_d                 = '0;
                        flags_d[FLAG_CARRY]     = alu_carry;
                        flags_d[FLAG_ZERO]      = (alu_res == '0);
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d             = ST_DONE;
                    out_d               = md_result;
                    flags_d[FLAG_DZ]    = md_dz;
                    flags_d[FLAG_CARRY] = md_carry;
                    flags_d[FLAG_ZERO]  = (md_result == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out) && $stable(flags)));

    a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
        in_ready |-> (state_q == ST_IDLE));

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8 with an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [3:0]   code = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic [2:0]   flags;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+2:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .code     (code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flags    (flags),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: results straight from arithmetic on wide integers
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [2:0] f, output int lat);
    longint ua, ub, t, m;
    logic cy, dz;
    logic [W-1:0] x, y;
    ua = a; ub = b; m = longint'(1) << W;
    x = a; y = b; cy = 1'b0; dz = 1'b0; t = 0;
    case (c)
      4'h0: begin t = ua + ub; cy = (t >= m); t = t % m; end
      4'h1: begin t = (ua - ub + m) % m; cy = (ua < ub); end
      4'h2: begin t = ua * ub; cy = (t >= m); t = t % m; end
      4'h3: begin if (ub == 0) begin t = m - 1; dz = 1'b1; end else t = ua / ub; end
      4'h4: t = longint'(x & y);
      4'h5: t = longint'(x | y);
      4'h6: t = longint'(~x);
      4'h7: t = longint'(~y);
      4'h8: t = longint'(x ^ y);
      4'h9: t = longint'(~(x ^ y));
      4'hA: t = longint'(~(x & y));
      4'hB: t = longint'(~(x | y));
      4'hC: t = (ub >= W) ? 0 : (ua * (longint'(1) << ub)) % m;
      4'hD: t = (ub >= W) ? 0 : ua / (longint'(1) << ub);
      4'hE: begin t = ua + 1; cy = (t >= m); t = t % m; end
      default: begin t = (ua + m - 1) % m; cy = (ua == 0); end
    endcase
    r = t[W-1:0];
    f = {dz, cy, (r == '0)};
    lat = (c == 4'h2 || c == 4'h3) ? W + 1 : 1;
  endfunction

  // driver + scoreboard for one operation; hold = cycles out_ready stays low after out_valid
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] er;
    logic [2:0]   ef;
    logic [W+2:0] e;
    int elat, lat, g;
    model(c, a, b, er, ef, elat);
    exp_q.push_back({ef, er});
    code = c; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin tick(); g++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    tick();
    in_valid = 1'b0;
    op1 = W'($urandom); op2 = W'($urandom); code = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 3 * W) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy_in_ready: in_ready=%b required 0 at lat %0d", tag, in_ready, lat);
      end
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== elat || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: got %0d (out_valid=%b) required %0d", tag, lat, out_valid, elat);
    end
    n_cmp++;
    if (out !== e[W-1:0]) begin
      n_err++;
      $display("FAIL %s out: got %h required %h", tag, out, e[W-1:0]);
    end
    n_cmp++;
    if (flags !== e[W+2:W]) begin
      n_err++;
      $display("FAIL %s flags: got %b required %b", tag, flags, e[W+2:W]);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== e[W-1:0] || flags !== e[W+2:W] || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid=%b out=%h flags=%b in_ready=%b required 1 %h %b 0",
                 tag, h, out_valid, out, flags, in_ready, e[W-1:0], e[W+2:W]);
      end
    end
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s consume_in_ready: got %b required 0", tag, in_ready);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s after_consume: out_valid=%b in_ready=%b required 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; code = 4'h0; op1 = 8'hFF; op2 = 8'h01; out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
    n_cmp++;
    if (out !== '0) begin n_err++; $display("FAIL reset out: got %h required 00", out); end
    n_cmp++;
    if (flags !== 3'b000) begin n_err++; $display("FAIL reset flags: got %b required 000", flags); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(4'h0, 8'hFF, 8'h01, 0, "add_ff_01");
    run_op(4'h2, 8'h10, 8'h20, 0, "mul_10_20");
    run_op(4'h3, 8'h64, 8'h07, 1, "div_64_07");
    run_op(4'h3, 8'h05, 8'h00, 0, "div_by_zero");
    run_op(4'hC, 8'h81, 8'h01, 0, "shl_81_1");
    run_op(4'hD, 8'h80, 8'h08, 5, "shr_80_8_hold");
    run_op(4'hC, 8'hFF, 8'h09, 0, "shl_oob");
    run_op(4'hE, 8'hFF, 8'h00, 0, "inc_wrap");
    run_op(4'hF, 8'h00, 8'h00, 0, "dec_wrap");
    run_op(4'h2, 8'hFF, 8'hFF, 2, "mul_ff_ff");
  endtask

  task automatic test_reset_midop();
    code = 4'h3; op1 = 8'h64; op2 = 8'h07; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b out=%h flags=%b required 1 0 00 000",
               in_ready, out_valid, out, flags);
    end
    for (int i = 0; i < W + 4; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midop_no_result cycle %0d: out_valid=%b required 0", i, out_valid);
      end
    end
    // reset in DONE with out_ready high must still clear the result
    code = 4'h0; op1 = 8'h01; op2 = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 8'h02) begin
      n_err++;
      $display("FAIL done_pre_reset: out_valid=%b out=%h required 1 02", out_valid, out);
    end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== '0 || flags !== 3'b000) begin
      n_err++;
      $display("FAIL done_reset: out_valid=%b in_ready=%b out=%h flags=%b required 0 1 00 000",
               out_valid, in_ready, out, flags);
    end
    run_op(4'h1, 8'h03, 8'h05, 0, "sub_after_reset");
  endtask

  task automatic test_random();
    logic [3:0]   c;
    logic [W-1:0] a, b;
    for (int i = 0; i < 48; i++) begin
      c = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = (c == 4'hC || c == 4'hD) ? W'($urandom_range(0, 11)) : W'($urandom);
      if (c == 4'h3 && $urandom_range(0, 5) == 0) b = '0;
      run_op(c, a, b, $urandom_range(0, 3), $sformatf("rand%0d_op%h", i, c));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom_range(0, 9)), 0,
             $sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 4..32).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op1  input  WIDTH  first operand.
REQ-007 Port: op2  input  WIDTH  second operand / shift amount.
REQ-008 Port: code  input  4  opcode (0x0..0xF).
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out  output  WIDTH  result.
REQ-012 Port: flags  output  3  {dz, carry, zero}.

Function
REQ-013 Opcodes SHALL be: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 not op1, 7 not op2, 8 xor, 9 xnor, A nand, B nor, C shl, D shr, E op1+1, F op1-1.
REQ-014 Request SHALL be accepted on a cycle with in_valid && in_ready; op1/op2/code SHALL be registered then and later changes ignored.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be high only in IDLE.
REQ-016 IDLE->DONE on accept of any opcode except 2/3; out_valid high the next cycle (latency 1).
REQ-017 IDLE->BUSY on accept of opcode 2 or 3; iterative unit runs WIDTH cycles, BUSY->DONE, out_valid high exactly WIDTH+1 cycles after accept.
REQ-018 DONE->IDLE on out_valid && out_ready; out and flags SHALL hold stable while out_valid high and out_ready low.
REQ-019 No new request SHALL be accepted in the cycle the result is consumed (in_ready rises the cycle after).
REQ-020 add/E: out = low WIDTH bits; carry = carry-out of bit WIDTH-1.
REQ-021 sub/F: out = modulo 2^WIDTH difference; carry = borrow (op1 < subtrahend).
REQ-022 mul: unsigned shift-add; out = low WIDTH bits of product; carry = 1 iff upper WIDTH bits nonzero.
REQ-023 div: unsigned restoring division; out = quotient; remainder discarded.
REQ-024 div with op2 = 0: out = all ones, dz = 1, still WIDTH+1 latency; dz = 0 for every other case.
REQ-025 shl/shr: logical, zero fill; shift amount >= WIDTH SHALL give out = 0.
REQ-026 Logic ops (4..B): carry = 0.
REQ-027 zero = 1 iff out == 0, for all opcodes.

Reset
REQ-028 rst SHALL force state IDLE, out = 0, flags = 0, out_valid = 0, in_ready = 1 on the next clock edge.
REQ-029 rst asserted in BUSY or DONE SHALL abandon the operation; no out_valid pulse for it.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-031 Package seq_alu_pkg SHALL hold opcode constants (OP_ADD..OP_DEC), FSM state typedef, flag bit indices.
REQ-032 Sub-module seq_alu_muldiv SHALL implement the iterative multiply/divide (start, done, WIDTH-cycle counter, shared accumulator); all other ops in the top level.
REQ-033 The block SHALL be fully synchronous, no latches, no combinational path from in_valid to out_valid.

Verification (WIDTH=8)
REQ-034 add 0xFF+0x01, out_ready=1 -> out_valid cycle after accept, out=0x00, flags carry=1 zero=1.
REQ-035 mul 0x10*0x20 -> out_valid 9 cycles after accept, out=0x00, carry=1, zero=1; in_ready low throughout.
REQ-036 div 0x64/0x07 -> out=0x0E after 9 cycles; div 0x05/0x00 -> out=0xFF, dz=1.
REQ-037 shl 0x81 by 0x01 -> 0x02; shr 0x80 by 0x08 -> 0x00 zero=1; out_ready held low 5 cycles -> out/flags stable, in_ready=0.
REQ-038 rst pulsed 3 cycles into a div -> no out_valid, in_ready=1 next cycle, subsequent sub 0x03-0x05 -> out=0xFE carry=1.
